// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: owner encoding and default widths.
// Also reused by the CPU controller, which decodes the same owner encoding.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_CNT_W  = 16;

   // Which requester's access was issued to memory in the previous cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } owner_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; asynchronous active-low clear.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch (I) and load/store (D)
// requesters; one access per cycle, ack and read data one cycle after issue.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   owner_e owner_q, owner_d;
   grant_e last_grant_q, last_grant_d;
   logic   d_we_q, d_we_d;

   logic i_elig, d_elig, tie, grant_i, grant_d;

   // Gating with reset keeps the memory port quiet while reset is held, even with requests up
   always_comb begin
      i_elig  = reset & i_req & (owner_q != OWN_I);
      d_elig  = reset & d_req & (owner_q != OWN_D);
      tie     = i_elig & d_elig;
      grant_i = i_elig & (~d_elig | (last_grant_q == GNT_D));
      grant_d = d_elig & (~i_elig | (last_grant_q == GNT_I));
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_i) begin
         mem_en   = 1'b1;
         mem_addr = i_addr;
      end else if (grant_d) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   always_comb begin
      owner_d      = OWN_NONE;
      last_grant_d = last_grant_q;
      d_we_d       = 1'b0;
      if (grant_i) begin
         owner_d      = OWN_I;
         last_grant_d = GNT_I;
      end else if (grant_d) begin
         owner_d      = OWN_D;
         last_grant_d = GNT_D;
         d_we_d       = d_we;
      end
   end

   // last_grant resets to I so that D wins the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q      <= OWN_NONE;
         last_grant_q <= GNT_I;
         d_we_q       <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         d_we_q       <= d_we_d;
      end
   end

   assign i_ack   = (owner_q == OWN_I);
   assign d_ack   = (owner_q == OWN_D);
   assign i_rdata = i_ack ? mem_rdata : '0;
   // A write ack carries no data; mem_rdata still holds whatever the last read returned
   assign d_rdata = (d_ack && !d_we_q) ? mem_rdata : '0;

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_conflict_cnt (
      .clk_i   (clk),
      .rst_ni  (reset),
      .inc_i   (tie),
      .count_o (conflict_cnt)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table plus an ack/data scoreboard;
// a second instance with a 4-bit conflict counter shares the stimulus to exercise saturation.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          i_ack, d_ack, mem_en, mem_we;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] conflict_cnt;

   logic          s_i_ack, s_d_ack, s_mem_en, s_mem_we;
   logic [DW-1:0] s_i_rdata, s_d_rdata, s_mem_wdata;
   logic [AW-1:0] s_mem_addr;
   logic [3:0]    s_cnt;

   logic [DW-1:0] mem     [0:255];
   logic [DW-1:0] ref_mem [0:255];

   typedef struct packed {
      logic        mem_en;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        i_ack;
      logic        d_ack;
      logic [15:0] cnt;
   } out_t;

   typedef struct packed {
      logic        rst;
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [1:0]  gnt;   // 0 none, 1 I, 2 D
      out_t        exp;
   } row_t;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } sb_t;

   sb_t  sb_q[$];
   row_t rows[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_ack        (i_ack),
      .i_rdata      (i_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_ack        (d_ack),
      .d_rdata      (d_rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .conflict_cnt (conflict_cnt)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_small (
      .clk          (clk),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_ack        (s_i_ack),
      .i_rdata      (s_i_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_ack        (s_d_ack),
      .d_rdata      (s_d_rdata),
      .mem_en       (s_mem_en),
      .mem_we       (s_mem_we),
      .mem_addr     (s_mem_addr),
      .mem_wdata    (s_mem_wdata),
      .mem_rdata    (mem_rdata),
      .conflict_cnt (s_cnt)
   );

   always #5 clk = ~clk;

   // Memory model: one-cycle read latency, driven by the main instance
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic row_t mk(input logic rst, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dd, input logic [1:0] g,
                               input logic iack, input logic dack, input logic [15:0] c);
      row_t r;
      r = '0;
      r.rst = rst; r.i_req = ir; r.i_addr = ia;
      r.d_req = dr; r.d_we = dw; r.d_addr = da; r.d_wdata = dd; r.gnt = g;
      r.exp.i_ack = iack; r.exp.d_ack = dack; r.exp.cnt = c;
      if (g == 2'd1) begin
         r.exp.mem_en = 1'b1; r.exp.mem_addr = ia;
      end else if (g == 2'd2) begin
         r.exp.mem_en = 1'b1; r.exp.mem_we = dw; r.exp.mem_addr = da; r.exp.mem_wdata = dd;
      end
      return r;
   endfunction

   task automatic run_row(input row_t r, input int idx);
      out_t act, s_act, s_exp;
      sb_t  e;
      @(posedge clk);
      #1;
      reset = r.rst; i_req = r.i_req; i_addr = r.i_addr;
      d_req = r.d_req; d_we = r.d_we; d_addr = r.d_addr; d_wdata = r.d_wdata;
      #2;
      act   = '{mem_en, mem_we, mem_addr, mem_wdata, i_ack, d_ack, conflict_cnt};
      s_act = '{s_mem_en, s_mem_we, s_mem_addr, s_mem_wdata, s_i_ack, s_d_ack, 16'(s_cnt)};
      s_exp = r.exp;
      if (r.exp.cnt > 16'd15) s_exp.cnt = 16'd15;
      check($sformatf("row%0d", idx), act, r.exp);
      check($sformatf("row%0d_cnt4", idx), s_act, s_exp);
      if (!i_ack) check($sformatf("row%0d_i_rdata_idle", idx), i_rdata, '0);
      if (!d_ack) check($sformatf("row%0d_d_rdata_idle", idx), d_rdata, '0);
      if (i_ack || d_ack) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL row%0d_sb: got ack required no ack (nothing outstanding)", idx);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("row%0d_sb_who", idx), d_ack, e.is_d);
            check($sformatf("row%0d_sb_data", idx), d_ack ? d_rdata : i_rdata, e.data);
            check($sformatf("row%0d_sb_data4", idx), s_d_ack ? s_d_rdata : s_i_rdata, e.data);
         end
      end
      if (!r.rst) sb_q.delete();
      if (r.gnt == 2'd1) begin
         sb_q.push_back('{1'b0, ref_mem[r.i_addr[7:0]]});
      end else if (r.gnt == 2'd2) begin
         sb_q.push_back('{1'b1, r.d_we ? 32'h0 : ref_mem[r.d_addr[7:0]]});
         if (r.d_we) ref_mem[r.d_addr[7:0]] = r.d_wdata;
      end
   endtask

   initial begin
      logic [1:0] w;
      for (int i = 0; i < 256; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      mem[0] = 32'h1111_0000; ref_mem[0] = 32'h1111_0000;
      mem[3] = 32'h0000_3333; ref_mem[3] = 32'h0000_3333;
      mem[5] = 32'h2002_000A; ref_mem[5] = 32'h2002_000A;
      mem[7] = 32'h7777_0007; ref_mem[7] = 32'h7777_0007;
      reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
      #1 reset = 1'b0;

      //           rst ir ia  dr dw da     dd            g  ia da cnt
      rows.push_back(mk(0, 1, 5,  0, 0, 0,     0,            0, 0, 0, 0)); // held in reset
      rows.push_back(mk(1, 1, 5,  0, 0, 0,     0,            1, 0, 0, 0)); // I alone issues
      rows.push_back(mk(1, 1, 5,  0, 0, 0,     0,            0, 1, 0, 0)); // ack cycle
      rows.push_back(mk(1, 1, 5,  0, 0, 0,     0,            1, 0, 0, 0)); // reissue in N+2
      rows.push_back(mk(0, 1, 5,  0, 0, 0,     0,            0, 0, 0, 0)); // reset mid-access
      rows.push_back(mk(1, 1, 0,  1, 0, 7,     0,            2, 0, 0, 0)); // first tie -> D
      rows.push_back(mk(1, 1, 0,  1, 0, 7,     0,            1, 0, 1, 1));
      rows.push_back(mk(1, 1, 0,  1, 0, 7,     0,            2, 1, 0, 1));
      rows.push_back(mk(1, 1, 0,  1, 0, 7,     0,            1, 0, 1, 1));
      rows.push_back(mk(1, 1, 0,  1, 0, 7,     0,            2, 1, 0, 1));
      rows.push_back(mk(1, 0, 0,  0, 0, 0,     0,            0, 0, 1, 1));
      rows.push_back(mk(1, 1, 3,  1, 0, 5,     0,            1, 0, 0, 1)); // tie, last=D -> I
      rows.push_back(mk(1, 1, 3,  1, 0, 5,     0,            2, 1, 0, 2));
      rows.push_back(mk(1, 0, 0,  0, 0, 0,     0,            0, 0, 1, 2));
      rows.push_back(mk(1, 0, 0,  1, 1, 16,    32'hDEADBEEF, 2, 0, 0, 2)); // D write
      rows.push_back(mk(1, 0, 0,  1, 1, 16,    32'hDEADBEEF, 0, 0, 1, 2));
      rows.push_back(mk(1, 0, 0,  1, 0, 16,    0,            2, 0, 0, 2)); // D read back
      rows.push_back(mk(1, 0, 0,  1, 0, 16,    0,            0, 0, 1, 2));
      rows.push_back(mk(1, 0, 0,  0, 0, 0,     0,            0, 0, 0, 2));
      foreach (rows[k]) run_row(rows[k], k);

      // Twenty isolated ties: the 4-bit counter must stick at 15
      for (int k = 0; k < 20; k++) begin
         w = (k % 2 == 0) ? 2'd1 : 2'd2;
         run_row(mk(1, 1, 0, 1, 0, 7, 0, w, 0, 0, 16'(2 + k)), 100 + 2 * k);
         run_row(mk(1, 0, 0, 0, 0, 0, 0, 0, w == 2'd1, w == 2'd2, 16'(3 + k)), 101 + 2 * k);
      end
      run_row(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 22), 200);
      check("cnt4_saturated", s_cnt, 4'hF);
      check("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
